// File: rtl/deque_cmd_master.sv
// Command-side initiator for the dual deque: one command in, deque strobes out, one response back.
// Define DQM_ERR_CNT_EN to add the saturating refused-command counter (err_count, STATUS[7:4]).
module deque_cmd_master #(
    parameter int RD_LAT = 0,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_deque,
    input  logic              cmd_end,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              dq_select,
    output logic              dq_end,
    output logic              dq_push,
    output logic              dq_pop,
    output logic [DATA_W-1:0] dq_wdata,
    input  logic [DATA_W-1:0] dq_rdata,
    input  logic              d0_empty,
    input  logic              d0_full,
    input  logic              d1_empty,
    input  logic              d1_full
`ifdef DQM_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_MOVE, OP_STATUS} op_e;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MPUSH, S_RESP} state_e;

    state_e            state;
    op_e               op_q;
    logic              deque_q;
    logic              end_q;
    logic [DATA_W-1:0] data_q;

    logic       tgt_full, tgt_empty, oth_full;
    logic       push_ok, pop_ok, issue_err;
    logic [7:0] status_byte;

    // Flags are only meaningful in ISSUE; the decision is taken and the strobe issued in that cycle.
    assign tgt_full  = deque_q ? d1_full  : d0_full;
    assign tgt_empty = deque_q ? d1_empty : d0_empty;
    assign oth_full  = deque_q ? d0_full  : d1_full;
    assign push_ok   = (op_q == OP_PUSH) && !tgt_full;
    assign pop_ok    = ((op_q == OP_POP)  && !tgt_empty) ||
                       ((op_q == OP_MOVE) && !tgt_empty && !oth_full);
    assign issue_err = (op_q != OP_STATUS) && !(push_ok || pop_ok);

`ifdef DQM_ERR_CNT_EN
    assign status_byte = {err_count[3:0], d1_full, d1_empty, d0_full, d0_empty};
`else
    assign status_byte = {4'h0, d1_full, d1_empty, d0_full, d0_empty};
`endif

    // Gated with rst so the block never advertises readiness while held in reset.
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_RESP);

    // Strobes decode straight from state, so an async reset kills them in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        dq_select = 1'b0;
        dq_end    = 1'b0;
        dq_push   = 1'b0;
        dq_pop    = 1'b0;
        dq_wdata  = '0;
        case (state)
            S_ISSUE: begin
                dq_select = deque_q;
                dq_end    = end_q;
                dq_push   = push_ok;
                dq_pop    = pop_ok;
                if (push_ok) dq_wdata = data_q;
            end
            S_WAIT: begin
                dq_select = deque_q;
                dq_end    = end_q;
            end
            S_MPUSH: begin
                dq_select = ~deque_q;
                dq_end    = data_q[0];
                dq_push   = 1'b1;
                dq_wdata  = rsp_data;
            end
            default: ;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_PUSH;
            deque_q  <= 1'b0;
            end_q    <= 1'b0;
            data_q   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q    <= op_e'(cmd_op);
                        deque_q <= cmd_deque;
                        end_q   <= cmd_end;
                        data_q  <= cmd_data;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_err  <= issue_err;
                    rsp_data <= '0;
                    if (issue_err) begin
                        state <= S_RESP;
                    end else begin
                        case (op_q)
                            OP_STATUS: begin
                                rsp_data <= DATA_W'(status_byte);
                                state    <= S_RESP;
                            end
                            OP_PUSH: state <= S_RESP;
                            default: begin
                                // POP and MOVE: rsp_data doubles as the holding register for a moved word.
                                if (RD_LAT == 0) begin
                                    rsp_data <= dq_rdata;
                                    state    <= (op_q == OP_MOVE) ? S_MPUSH : S_RESP;
                                end else begin
                                    state <= S_WAIT;
                                end
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    rsp_data <= dq_rdata;
                    state    <= (op_q == OP_MOVE) ? S_MPUSH : S_RESP;
                end
                S_MPUSH: state <= S_RESP;
                S_RESP:  if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DQM_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= 8'h00;
        else if (state == S_ISSUE && issue_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_deque_cmd_master.sv
// Bench for deque_cmd_master: drives an RD_LAT=0 and an RD_LAT=1 instance, each attached to a
// small dual-deque model, and checks responses, latency and strobes against queue-based expectations.
module tb_deque_cmd_master;

    localparam logic [1:0] OP_PUSH = 2'd0, OP_POP = 2'd1, OP_MOVE = 2'd2, OP_STATUS = 2'd3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cmd_valid [2], cmd_ready [2], cmd_deque [2], cmd_end [2];
    logic       rsp_valid [2], rsp_ready [2], rsp_err [2];
    logic       dq_select [2], dq_end [2], dq_push [2], dq_pop [2];
    logic       d0_empty [2], d0_full [2], d1_empty [2], d1_full [2];
    logic [1:0] cmd_op [2];
    logic [7:0] cmd_data [2], rsp_data [2], dq_wdata [2], dq_rdata [2];
`ifdef DQM_ERR_CNT_EN
    logic [7:0] err_count [2];
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference deques (index inst*2 + deque); front = end 0, back = end 1.
    logic [7:0] rq [4][$];
    int         ref_errs [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [7:0] mem [2][DEPTH];
        int         cnt [2];
        logic [7:0] rd_q, peek;

        deque_cmd_master #(.RD_LAT(g), .DATA_W(8)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_op    (cmd_op[g]),
            .cmd_deque (cmd_deque[g]),
            .cmd_end   (cmd_end[g]),
            .cmd_data  (cmd_data[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .dq_select (dq_select[g]),
            .dq_end    (dq_end[g]),
            .dq_push   (dq_push[g]),
            .dq_pop    (dq_pop[g]),
            .dq_wdata  (dq_wdata[g]),
            .dq_rdata  (dq_rdata[g]),
            .d0_empty  (d0_empty[g]),
            .d0_full   (d0_full[g]),
            .d1_empty  (d1_empty[g]),
            .d1_full   (d1_full[g])
`ifdef DQM_ERR_CNT_EN
            ,
            .err_count (err_count[g])
`endif
        );

        // Dual-deque model: index 0 is end 0, index cnt-1 is end 1.
        always_comb begin
            peek = 8'h00;
            if (cnt[dq_select[g]] > 0)
                peek = dq_end[g] ? mem[dq_select[g]][cnt[dq_select[g]] - 1] : mem[dq_select[g]][0];
        end

        assign d0_empty[g] = (cnt[0] == 0);
        assign d0_full[g]  = (cnt[0] == DEPTH);
        assign d1_empty[g] = (cnt[1] == 0);
        assign d1_full[g]  = (cnt[1] == DEPTH);
        assign dq_rdata[g] = (g == 0) ? peek : rd_q;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt[0] <= 0;
                cnt[1] <= 0;
                rd_q   <= 8'h00;
            end else begin
                if (dq_push[g] && cnt[dq_select[g]] < DEPTH) begin
                    if (dq_end[g]) begin
                        mem[dq_select[g]][cnt[dq_select[g]]] <= dq_wdata[g];
                    end else begin
                        for (int k = 1; k < DEPTH; k++) mem[dq_select[g]][k] <= mem[dq_select[g]][k-1];
                        mem[dq_select[g]][0] <= dq_wdata[g];
                    end
                    cnt[dq_select[g]] <= cnt[dq_select[g]] + 1;
                end
                if (dq_pop[g] && cnt[dq_select[g]] > 0) begin
                    rd_q <= peek;
                    if (!dq_end[g])
                        for (int k = 0; k < DEPTH - 1; k++) mem[dq_select[g]][k] <= mem[dq_select[g]][k+1];
                    cnt[dq_select[g]] <= cnt[dq_select[g]] - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int sat_errs(input int i);
        return (ref_errs[i] > 255) ? 255 : ref_errs[i];
    endfunction

    function automatic logic [3:0] status_hi(input int i);
`ifdef DQM_ERR_CNT_EN
        return 4'(sat_errs(i));
`else
        return (i < 0) ? 4'hF : 4'h0;
`endif
    endfunction

    // Reference model: predicts the response and updates the reference deques.
    task automatic ref_cmd(input int i, input logic [1:0] op, input logic dq, input logic en,
                           input logic [7:0] data, output logic [7:0] e_data, output logic e_err);
        int s = i*2 + int'(dq);
        int o = i*2 + 1 - int'(dq);
        logic [7:0] v;
        e_data = 8'h00;
        e_err  = 1'b0;
        case (op)
            OP_PUSH: begin
                if (rq[s].size() == DEPTH) e_err = 1'b1;
                else if (en) rq[s].push_back(data);
                else rq[s].push_front(data);
            end
            OP_POP: begin
                if (rq[s].size() == 0) e_err = 1'b1;
                else e_data = en ? rq[s].pop_back() : rq[s].pop_front();
            end
            OP_MOVE: begin
                if (rq[s].size() == 0 || rq[o].size() == DEPTH) begin
                    e_err = 1'b1;
                end else begin
                    v = en ? rq[s].pop_back() : rq[s].pop_front();
                    if (data[0]) rq[o].push_back(v);
                    else rq[o].push_front(v);
                    e_data = v;
                end
            end
            default: e_data = {status_hi(i), rq[i*2+1].size() == DEPTH, rq[i*2+1].size() == 0,
                               rq[i*2].size() == DEPTH, rq[i*2].size() == 0};
        endcase
        if (e_err) ref_errs[i]++;
    endtask

    // Issue one command on instance i and check response, latency and strobes.
    task automatic apply(input int i, input logic [1:0] op, input logic dq, input logic en,
                         input logic [7:0] data, input logic [7:0] x_data, input logic x_err,
                         input logic chk_data, input int hold, input string tag);
        int t = 0, lat = 1, npush = 0, npop = 0, both = 0, x_lat;
        logic [7:0] wd = 8'h00, held;
        logic x_push, x_pop;
        @(negedge clk);
        cmd_valid[i] = 1'b1; cmd_op[i] = op; cmd_deque[i] = dq; cmd_end[i] = en;
        cmd_data[i] = data; rsp_ready[i] = 1'b0;
        while (!cmd_ready[i] && t < 20) begin @(negedge clk); t++; end
        check({tag, "_ready"}, 32'(t < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        while (!rsp_valid[i] && lat < 20) begin
            if (dq_push[i]) begin npush++; wd = dq_wdata[i]; end
            if (dq_pop[i]) npop++;
            if (dq_push[i] && dq_pop[i]) both++;
            @(negedge clk);
            lat++;
        end
        x_lat  = (x_err || op == OP_PUSH || op == OP_STATUS) ? 2 : ((op == OP_POP) ? 2 + i : 3 + i);
        x_push = !x_err && (op == OP_PUSH || op == OP_MOVE);
        x_pop  = !x_err && (op == OP_POP  || op == OP_MOVE);
        check({tag, "_lat"}, 32'(lat), 32'(x_lat));
        check({tag, "_err"}, 32'(rsp_err[i]), 32'(x_err));
        if (chk_data) check({tag, "_data"}, 32'(rsp_data[i]), 32'(x_data));
        check({tag, "_npush"}, 32'(npush), 32'(x_push));
        check({tag, "_npop"}, 32'(npop), 32'(x_pop));
        check({tag, "_overlap"}, 32'(both), 32'd0);
        if (x_push) check({tag, "_wdata"}, 32'(wd), (op == OP_PUSH) ? 32'(data) : 32'(x_data));
`ifdef DQM_ERR_CNT_EN
        check({tag, "_errcnt"}, 32'(err_count[i]), 32'(sat_errs(i)));
`endif
        held = rsp_data[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid[i]), 32'd1);
            check({tag, "_hold_data"}, 32'(rsp_data[i]), 32'(held));
            check({tag, "_hold_cmdrdy"}, 32'(cmd_ready[i]), 32'd0);
        end
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        check({tag, "_done"}, {30'd0, rsp_valid[i], cmd_ready[i]}, 32'b01);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       dq;
        logic       en;
        logic [7:0] data;
        logic [7:0] x_data;  // STATUS rows hold the flag nibble only
        logic       x_err;
        logic       chk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] op, input logic dq, input logic en, input logic [7:0] data,
                       input logic [7:0] xd, input logic xe, input logic chk);
        vec_t v;
        v.op = op; v.dq = dq; v.en = en; v.data = data; v.x_data = xd; v.x_err = xe; v.chk = chk;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] e_data;
        logic       e_err;
        logic [1:0] op;
        logic       dq, en;
        logic [7:0] data;

        add(OP_STATUS, 0, 0, 8'h00, 8'h05, 0, 1);
        add(OP_PUSH,   0, 0, 8'hA5, 8'h00, 0, 0);
        add(OP_POP,    0, 0, 8'h00, 8'hA5, 0, 1);
        add(OP_POP,    1, 0, 8'h00, 8'h00, 1, 1);   // empty d1
        add(OP_PUSH,   0, 0, 8'h3C, 8'h00, 0, 0);
        add(OP_MOVE,   0, 1, 8'h00, 8'h3C, 0, 1);   // d0/end1 -> d1/end0
        add(OP_STATUS, 0, 0, 8'h00, 8'h01, 0, 1);
        for (int k = 1; k <= 7; k++) add(OP_PUSH, 1, 1, 8'(k), 8'h00, 0, 0);
        add(OP_STATUS, 0, 0, 8'h00, 8'h09, 0, 1);
        add(OP_PUSH,   1, 0, 8'hFF, 8'h00, 1, 1);   // d1 full
        add(OP_PUSH,   0, 0, 8'h77, 8'h00, 0, 0);
        add(OP_MOVE,   0, 0, 8'h01, 8'h00, 1, 1);   // destination d1 full
        add(OP_STATUS, 0, 0, 8'h00, 8'h08, 0, 1);
        add(OP_POP,    1, 0, 8'h00, 8'h3C, 0, 1);
        for (int k = 1; k <= 7; k++) add(OP_POP, 1, 0, 8'h00, 8'(k), 0, 1);
        add(OP_POP,    0, 1, 8'h00, 8'h77, 0, 1);
        add(OP_STATUS, 0, 0, 8'h00, 8'h05, 0, 1);

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = 2'd0; cmd_deque[i] = 1'b0; cmd_end[i] = 1'b0;
            cmd_data[i] = 8'h00; rsp_ready[i] = 1'b0; ref_errs[i] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_cmd_ready", i), 32'(cmd_ready[i]), 32'd0);
            check($sformatf("rst%0d_outs", i),
                  {rsp_valid[i], rsp_err[i], rsp_data[i], dq_push[i], dq_pop[i],
                   dq_select[i], dq_end[i], dq_wdata[i]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("rel%0d_cmd_ready", i), 32'(cmd_ready[i]), 32'd1);

        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < tbl.size(); r++) begin
                ref_cmd(i, tbl[r].op, tbl[r].dq, tbl[r].en, tbl[r].data, e_data, e_err);
                apply(i, tbl[r].op, tbl[r].dq, tbl[r].en, tbl[r].data,
                      (tbl[r].op == OP_STATUS) ? (tbl[r].x_data | {status_hi(i), 4'h0}) : tbl[r].x_data,
                      tbl[r].x_err, tbl[r].chk, 0, $sformatf("tbl%0d_%0d", i, r));
            end
        end

        // Back-pressure: response held for 5 cycles.
        ref_cmd(1, OP_STATUS, 0, 0, 8'h00, e_data, e_err);
        apply(1, OP_STATUS, 0, 0, 8'h00, e_data, e_err, 1, 5, "hold");

        // Reset during MPUSH on the RD_LAT=0 instance.
        ref_cmd(0, OP_PUSH, 0, 0, 8'h5A, e_data, e_err);
        apply(0, OP_PUSH, 0, 0, 8'h5A, e_data, e_err, 0, 0, "pre_move");
        @(negedge clk);
        check("mv_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        cmd_valid[0] = 1'b1; cmd_op[0] = OP_MOVE; cmd_deque[0] = 1'b0; cmd_end[0] = 1'b0;
        cmd_data[0] = 8'h01;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("mv_issue_pop", 32'(dq_pop[0]), 32'd1);
        @(negedge clk);
        check("mv_mpush", {dq_push[0], dq_select[0], dq_end[0], dq_wdata[0]}, {3'b111, 8'h5A});
        rst = 1'b1;
        #1;
        check("mv_rst_push", 32'(dq_push[0]), 32'd0);
        check("mv_rst_ready_valid", {cmd_ready[0], rsp_valid[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mv_rel_ready", {cmd_ready[0], cmd_ready[1]}, 32'b11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mv_no_rsp%0d", k), {rsp_valid[0], dq_push[0], dq_pop[0]}, 32'd0);
        end
        for (int q = 0; q < 4; q++) rq[q].delete();
        ref_errs[0] = 0;
        ref_errs[1] = 0;
        ref_cmd(0, OP_STATUS, 0, 0, 8'h00, e_data, e_err);
        apply(0, OP_STATUS, 0, 0, 8'h00, e_data, e_err, 1, 0, "post_rst_status");

        // Randomized commands against the reference model.
        for (int n = 0; n < 300; n++) begin
            int i = n % 2;
            op   = 2'($urandom_range(0, 3));
            dq   = 1'($urandom_range(0, 1));
            en   = 1'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 255));
            ref_cmd(i, op, dq, en, data, e_data, e_err);
            apply(i, op, dq, en, data, e_data, e_err, !(op == OP_PUSH && !e_err),
                  $urandom_range(0, 2), $sformatf("rnd%0d_%0d", i, n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
